// File: rtl/tl_ctrl_pkg.sv
// Shared traffic-light definitions: phase vector layout and counter widths,
// common to tl_ctrl and the light datapath.
package tl_ctrl_pkg;

  localparam int TL_STATE_W = 4;
  localparam int S_INIT     = 0;
  localparam int S_G        = 1;
  localparam int S_Y        = 2;
  localparam int S_R        = 3;

  localparam int AGE_W      = 10;
  localparam int CYC_W      = 8;
  localparam int TL_MIN_G   = 64;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_INIT,
    PH_G,
    PH_Y,
    PH_R
  } phase_e;

endpackage

// File: rtl/tl_ctrl.sv
// Traffic-light phase sequencer: walks INIT/G/Y/R on datapath done flags,
// with pedestrian early green exit, stop-at-end-of-red and flag sanity check.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | stopped, state output all-zero, waits for start
// INIT    | datapath initialisation phase
// G       | green; ends on flag or pending ped request after MIN_G cycles
// Y       | yellow; Y->R serves a pending pedestrian request
// R       | red; returns to G, or to IDLE if a stop is pending
module tl_ctrl
  import tl_ctrl_pkg::*;
#(
  parameter int STATE_W = TL_STATE_W,
  parameter int MIN_G   = TL_MIN_G
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               ped_req,
  input  logic [STATE_W-1:0] int_flags,
  output logic [STATE_W-1:0] state,
  output logic               cnt_rst,
  output logic               ped_ack,
  output logic               busy,
  output logic [CYC_W-1:0]   cycles,
  output logic               flag_err
);

  localparam logic [AGE_W-1:0] MIN_G_AGE = AGE_W'(MIN_G);
  localparam logic [AGE_W-1:0] AGE_QUAL  = AGE_W'(2);

  phase_e             fsm, fsm_nxt;
  logic [AGE_W-1:0]   age;
  logic               ped_pending, stop_pending;
  logic [STATE_W-1:0] cur_bit;
  logic               aged, flag_cur, flag_other, moving, take_yr, take_rg, take_ri;

  function automatic logic [STATE_W-1:0] onehot(input phase_e p);
    logic [STATE_W-1:0] v;
    v = '0;
    case (p)
      PH_INIT: v[S_INIT] = 1'b1;
      PH_G:    v[S_G]    = 1'b1;
      PH_Y:    v[S_Y]    = 1'b1;
      PH_R:    v[S_R]    = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Flags in the first two cycles of a phase still reflect the previous count.
  assign cur_bit    = onehot(fsm);
  assign aged       = (age >= AGE_QUAL);
  assign flag_cur   = aged && |(int_flags & cur_bit);
  assign flag_other = aged && (fsm != PH_IDLE) && |(int_flags & ~cur_bit);

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      PH_IDLE: if (start) fsm_nxt = PH_INIT;
      PH_INIT: if (flag_cur) fsm_nxt = PH_G;
      PH_G:    if (flag_cur || (ped_pending && age >= MIN_G_AGE)) fsm_nxt = PH_Y;
      PH_Y:    if (flag_cur) fsm_nxt = PH_R;
      PH_R:    if (flag_cur) fsm_nxt = stop_pending ? PH_IDLE : PH_G;
      default: fsm_nxt = PH_IDLE;
    endcase
  end

  assign moving  = (fsm_nxt != fsm);
  assign take_yr = (fsm == PH_Y) && (fsm_nxt == PH_R);
  assign take_rg = (fsm == PH_R) && (fsm_nxt == PH_G);
  assign take_ri = (fsm == PH_R) && (fsm_nxt == PH_IDLE);
  assign busy    = |state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm          <= PH_IDLE;
      state        <= '0;
      cnt_rst      <= 1'b0;
      ped_ack      <= 1'b0;
      cycles       <= '0;
      flag_err     <= 1'b0;
      age          <= '0;
      ped_pending  <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      fsm     <= fsm_nxt;
      state   <= onehot(fsm_nxt);
      cnt_rst <= moving && (fsm_nxt != PH_IDLE);
      ped_ack <= take_yr && ped_pending;

      if (moving)          age <= '0;
      else if (age != '1)  age <= age + 1'b1;

      // A request arriving on the serving edge starts the next wait.
      if (take_yr)      ped_pending <= ped_req;
      else if (ped_req) ped_pending <= 1'b1;

      if (take_ri)                         stop_pending <= 1'b0;
      else if (stop && (fsm != PH_IDLE))   stop_pending <= 1'b1;

      if (take_rg && (cycles != '1)) cycles <= cycles + 1'b1;
      if (flag_other)                flag_err <= 1'b1;
    end
  end

endmodule

// File: doc/tl_ctrl.md
TL_CTRL -- requirements
Module: tl_ctrl

Interface
REQ-001 SHALL have parameter STATE_W, default 4, one-hot phase vector width (bits S_INIT=0, S_G=1, S_Y=2, S_R=3).
REQ-002 SHALL have parameter MIN_G, default 64, minimum green cycles before a pedestrian request can end green early.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse, leave IDLE.
REQ-006 SHALL have port stop  input  1  one-cycle pulse, return to IDLE at the end of the current R phase.
REQ-007 SHALL have port ped_req  input  1  pedestrian request; any high cycle is latched.
REQ-008 SHALL have port int_flags  input  STATE_W  phase-done flags from the light datapath.
REQ-009 SHALL have port state  output  STATE_W  registered one-hot phase to the datapath; all-zero means IDLE.
REQ-010 SHALL have port cnt_rst  output  1  registered, one-cycle datapath counter clear.
REQ-011 SHALL have port ped_ack  output  1  one-cycle pulse when a latched request is served.
REQ-012 SHALL have port busy  output  1  high when state is nonzero.
REQ-013 SHALL have port cycles  output  8  completed R-to-G rounds, saturating at 255.
REQ-014 SHALL have port flag_err  output  1  sticky datapath flag error.

Function
REQ-015 SHALL implement FSM IDLE, INIT, G, Y, R; state output is the one-hot of the current FSM state, all-zero in IDLE.
REQ-016 SHALL move IDLE->INIT on start; INIT->G, G->Y, Y->R and R->G on the qualified flag of the current phase.
REQ-017 SHALL take R->IDLE instead of R->G when stop_pending is set, then clear stop_pending; stop in IDLE is ignored.
REQ-018 SHALL assert cnt_rst in exactly the first cycle of each new nonzero state, including INIT; cnt_rst is 0 otherwise.
REQ-019 SHALL keep a local 10-bit age counter: cleared on each transition, +1 per cycle, saturating at 1023.
REQ-020 SHALL qualify int_flags[current] only when age >= 2; this masks stale flags computed from the previous phase count.
REQ-021 SHALL latch ped_req into ped_pending; a request arriving while ped_pending is already set is merged.
REQ-022 SHALL end G early (G->Y) when ped_pending=1 and age >= MIN_G, even if the G flag is low.
REQ-023 SHALL pulse ped_ack in the cycle of the next Y->R transition after pending is set, clear ped_pending there, and re-latch a ped_req present in that same cycle.
REQ-024 SHALL increment cycles on every R->G transition; it saturates and never wraps.
REQ-025 SHALL set flag_err when, with age >= 2, any int_flags bit other than the current phase bit is high; flag_err holds until reset, and the FSM keeps running.
REQ-026 SHALL give start priority over stop when both pulse in IDLE; start outside IDLE is ignored.
REQ-027 SHALL make simultaneous qualified flag and ped early-exit in G one transition, not two.

Reset
REQ-028 SHALL on reset low immediately force: FSM=IDLE, state=0, cnt_rst=0, ped_ack=0, busy=0, cycles=0, flag_err=0, age=0, ped_pending=0, stop_pending=0.
REQ-029 SHALL abort any phase on reset mid-operation, and after release wait in IDLE for a new start.

Structure
REQ-030 SHALL take STATE_W, the S_* bit indices and the counter widths from the shared definitions file also used by the light datapath.
REQ-031 SHALL be one module with no sub-modules; the top level instantiates tl_ctrl beside the datapath with state, cnt_rst and int_flags connected point-to-point.

Verification
REQ-032 SHALL cover: reset low, start at cycle 5 -> state=0001, cnt_rst=1 for one cycle, busy=1.
REQ-033 SHALL cover: a full round with the model datapath -> states 0001,0010,0100,1000,0010 in order, cycles=1, one cnt_rst per transition.
REQ-034 SHALL cover: ped_req pulse at G age 10 with MIN_G=64 -> G->Y at age 64, then ped_ack one cycle at Y->R.
REQ-035 SHALL cover: int_flags[S_Y] forced high during G at age 5 -> flag_err=1 and persists, sequence unchanged.
REQ-036 SHALL cover: stop pulse during G -> finishes Y and R, then state=0000 and busy=0; 256 rounds -> cycles=255.
REQ-037 SHALL cover: reset low mid-Y -> all outputs 0 at once; a stale flag at age 1 after a transition causes no transition.
